// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus for instr_encoder.
// slave = encoder side, master = request producer / memory observer.
interface instr_encoder_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_kind;
    logic [4:0]            req_rd;
    logic [4:0]            req_rs1;
    logic [4:0]            req_rs2;
    logic [12:0]           req_imm;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport slave (
        input  req_valid, req_kind, req_rd, req_rs1, req_rs2, req_imm,
        output req_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_kind, req_rd, req_rs1, req_rs2, req_imm,
        input  req_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I encoder/loader: packs ADDI/BNE/LW requests into imem words.
// ENC_CHECK_EN: reject reserved kinds and odd BNE offsets, set err.
module instr_encoder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_finish,
    instr_encoder_if.slave        bus,
    output logic [ADDR_WIDTH:0]   o_prog_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_full,
    output logic                  o_err
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_FULL
    } state_t;

    localparam int CAP = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_CAP = CAP[ADDR_WIDTH:0];

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   w_len_inc;
    logic                  r_fin;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_full;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  w_hs;
    logic                  w_bad;
    logic                  w_wr;
    logic [31:0]           w_enc;

    assign w_len_inc = r_len + LEN_ONE;
    assign w_hs = (r_state == S_ACCEPT) && bus.req_valid && !i_start;
    assign w_wr = w_hs && !w_bad;

`ifdef ENC_CHECK_EN
    logic r_err;

    assign w_bad = (bus.req_kind == 2'b11) ||
                   ((bus.req_kind == 2'b01) && bus.req_imm[0]);
    assign o_err = r_err;

    // Sticky reject flag, cleared only by a new session or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (i_start) begin
            r_err <= 1'b0;
        end else if (w_hs && w_bad) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unused_imm0;

    assign w_bad = 1'b0;
    assign o_err = 1'b0;
    assign w_unused_imm0 = bus.req_imm[0];
`endif

    // Pack the current request into its RV32I machine word.
    always_comb begin
        w_enc = 32'h0000_0013;
        unique case (bus.req_kind)
            2'b00: w_enc = {bus.req_imm[11:0], bus.req_rs1, 3'b000,
                            bus.req_rd, 7'b0010011};
            2'b01: w_enc = {bus.req_imm[12], bus.req_imm[10:5],
                            bus.req_rs2, bus.req_rs1, 3'b001,
                            bus.req_imm[4:1], bus.req_imm[11],
                            7'b1100011};
            2'b10: w_enc = {bus.req_imm[11:0], bus.req_rs1, 3'b010,
                            bus.req_rd, 7'b0000011};
            default: w_enc = 32'h0000_0013;
        endcase
    end

    // Next-state selection; start overrides everything.
    always_comb begin
        w_next = r_state;
        if (i_start) begin
            w_next = S_ACCEPT;
        end else begin
            unique case (r_state)
                S_IDLE: w_next = S_IDLE;
                S_ACCEPT: begin
                    if (bus.req_valid) begin
                        if (w_bad) begin
                            w_next = i_finish ? S_DONE : S_ACCEPT;
                        end else begin
                            w_next = S_WRITE;
                        end
                    end else if (i_finish) begin
                        w_next = S_DONE;
                    end
                end
                S_WRITE: begin
                    if (w_len_inc == LEN_CAP) begin
                        w_next = S_FULL;
                    end else if (r_fin) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_ACCEPT;
                    end
                end
                S_DONE: w_next = S_DONE;
                S_FULL: w_next = S_FULL;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // State register and status flags decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_ACCEPT);
            r_busy  <= (w_next == S_ACCEPT) || (w_next == S_WRITE);
            r_done  <= (w_next == S_DONE) || (w_next == S_FULL);
            r_full  <= (w_next == S_FULL);
        end
    end

    // Write port registers, pointer, length and latched finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ptr       <= '0;
            r_len       <= '0;
            r_fin       <= 1'b0;
        end else begin
            r_mem_we <= w_wr;
            if (w_wr) begin
                r_mem_addr  <= r_ptr;
                r_mem_wdata <= w_enc;
            end
            if (i_start) begin
                r_ptr <= '0;
                r_len <= '0;
                r_fin <= 1'b0;
            end else begin
                if (w_hs) begin
                    r_fin <= i_finish;
                end
                if (r_state == S_WRITE) begin
                    r_ptr <= r_ptr + PTR_ONE;
                    r_len <= w_len_inc;
                end
            end
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign o_prog_len    = r_len;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_full        = r_full;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: one task per scenario.
// A second instance with ADDR_WIDTH=2 exercises the FULL path.
module tb_instr_encoder;
    logic clk;
    logic rst;
    logic start_a;
    logic finish_a;
    logic start_b;
    logic finish_b;
    logic [8:0] len_a;
    logic [2:0] len_b;
    logic busy_a, done_a, full_a, err_a;
    logic busy_b, done_b, full_b, err_b;
    int n_checks;
    int n_errors;

    instr_encoder_if #(.ADDR_WIDTH(8)) bus_a ();
    instr_encoder_if #(.ADDR_WIDTH(2)) bus_b ();

    instr_encoder #(.ADDR_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .i_start(start_a), .i_finish(finish_a),
        .bus(bus_a), .o_prog_len(len_a), .o_busy(busy_a),
        .o_done(done_a), .o_full(full_a), .o_err(err_a)
    );

    instr_encoder #(.ADDR_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .i_start(start_b), .i_finish(finish_b),
        .bus(bus_b), .o_prog_len(len_b), .o_busy(busy_b),
        .o_done(done_b), .o_full(full_b), .o_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] kind, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [12:0] imm);
        bus_a.req_kind = kind;
        bus_a.req_rd   = rd;
        bus_a.req_rs1  = rs1;
        bus_a.req_rs2  = rs2;
        bus_a.req_imm  = imm;
    endtask

    // Hold valid until a handshake edge; returns just after it.
    task automatic send_a(output bit ok);
        ok = 1'b0;
        bus_a.req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus_a.req_ready === 1'b1) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        bus_a.req_valid = 1'b0;
        finish_a = 1'b0;
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL handshake_timeout: ready never seen, required 1");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_checks++;
        if ({bus_a.req_ready, bus_a.mem_we, busy_a, done_a, full_a, err_a}
            !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_flags_a: got %b required 000000",
                     {bus_a.req_ready, bus_a.mem_we, busy_a, done_a,
                      full_a, err_a});
        end
        n_checks++;
        if ({bus_a.mem_addr, bus_a.mem_wdata, len_a} !== 49'h0) begin
            n_errors++;
            $display("FAIL reset_data_a: addr %h wdata %h len %0d required 0",
                     bus_a.mem_addr, bus_a.mem_wdata, len_a);
        end
        n_checks++;
        if ({bus_b.req_ready, bus_b.mem_we, busy_b, done_b, full_b, len_b}
            !== 8'b0) begin
            n_errors++;
            $display("FAIL reset_b: got %b required 0",
                     {bus_b.req_ready, bus_b.mem_we, busy_b, done_b,
                      full_b, len_b});
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (bus_a.req_ready !== 1'b0 || busy_a !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: ready %b busy %b required 0 0",
                     bus_a.req_ready, busy_a);
        end
    endtask

    task automatic test_addi();
        bit ok;
        pulse_start_a();
        n_checks++;
        if (bus_a.req_ready !== 1'b1 || busy_a !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_after_start: ready %b busy %b required 1 1",
                     bus_a.req_ready, busy_a);
        end
        set_req(2'b00, 5'd1, 5'd0, 5'd0, 13'd5);
        send_a(ok);
        n_checks++;
        if (bus_a.mem_we !== 1'b1 || bus_a.mem_addr !== 8'd0 ||
            bus_a.mem_wdata !== 32'h0050_0093) begin
            n_errors++;
            $display("FAIL addi_write: we %b addr %h wdata %h required 1 00 00500093",
                     bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata);
        end
        step();
        n_checks++;
        if (len_a !== 9'd1 || bus_a.mem_we !== 1'b0 ||
            bus_a.req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL addi_after: len %0d we %b ready %b required 1 0 1",
                     len_a, bus_a.mem_we, bus_a.req_ready);
        end
    endtask

    task automatic test_lw_bne();
        bit ok;
        pulse_start_a();
        set_req(2'b10, 5'd2, 5'd1, 5'd0, 13'd4);
        send_a(ok);
        n_checks++;
        if (bus_a.mem_we !== 1'b1 || bus_a.mem_addr !== 8'd0 ||
            bus_a.mem_wdata !== 32'h0040_A103 || bus_a.req_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL lw_write: we %b addr %h wdata %h ready %b required 1 00 0040a103 0",
                     bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata,
                     bus_a.req_ready);
        end
        set_req(2'b01, 5'd31, 5'd1, 5'd2, -13'sd8);
        send_a(ok);
        n_checks++;
        if (bus_a.mem_we !== 1'b1 || bus_a.mem_addr !== 8'd1 ||
            bus_a.mem_wdata !== 32'hFE20_9CE3 || bus_a.req_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bne_write: we %b addr %h wdata %h ready %b required 1 01 fe209ce3 0",
                     bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata,
                     bus_a.req_ready);
        end
        step();
        n_checks++;
        if (len_a !== 9'd2) begin
            n_errors++;
            $display("FAIL lw_bne_len: got %0d required 2", len_a);
        end
    endtask

    task automatic test_finish_same_cycle();
        int extra;
        pulse_start_a();
        set_req(2'b00, 5'd4, 5'd3, 5'd0, 13'h0FFF);
        finish_a = 1'b1;
        bus_a.req_valid = 1'b1;
        step();
        bus_a.req_valid = 1'b0;
        finish_a = 1'b0;
        n_checks++;
        if (bus_a.mem_we !== 1'b1 || bus_a.mem_wdata !== 32'hFFF1_8213) begin
            n_errors++;
            $display("FAIL finish_write: we %b wdata %h required 1 fff18213",
                     bus_a.mem_we, bus_a.mem_wdata);
        end
        step();
        n_checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || bus_a.req_ready !== 1'b0 ||
            len_a !== 9'd1) begin
            n_errors++;
            $display("FAIL finish_done: done %b busy %b ready %b len %0d required 1 0 0 1",
                     done_a, busy_a, bus_a.req_ready, len_a);
        end
        extra = 0;
        bus_a.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus_a.mem_we === 1'b1) extra++;
        end
        bus_a.req_valid = 1'b0;
        n_checks++;
        if (extra !== 0 || len_a !== 9'd1 || done_a !== 1'b1) begin
            n_errors++;
            $display("FAIL done_ignores_req: writes %0d len %0d done %b required 0 1 1",
                     extra, len_a, done_a);
        end
    endtask

    task automatic test_start_wins();
        pulse_start_a();
        set_req(2'b00, 5'd1, 5'd0, 5'd0, 13'd9);
        bus_a.req_valid = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        bus_a.req_valid = 1'b0;
        n_checks++;
        if (bus_a.mem_we !== 1'b0 || bus_a.req_ready !== 1'b1 ||
            len_a !== 9'd0) begin
            n_errors++;
            $display("FAIL start_wins: we %b ready %b len %0d required 0 1 0",
                     bus_a.mem_we, bus_a.req_ready, len_a);
        end
    endtask

    task automatic test_reserved();
        bit ok;
        pulse_start_a();
        set_req(2'b11, 5'd7, 5'd7, 5'd7, 13'h1ABC);
        send_a(ok);
`ifdef ENC_CHECK_EN
        n_checks++;
        if (bus_a.mem_we !== 1'b0 || err_a !== 1'b1 ||
            bus_a.req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reserved_reject: we %b err %b ready %b required 0 1 1",
                     bus_a.mem_we, err_a, bus_a.req_ready);
        end
        step();
        n_checks++;
        if (len_a !== 9'd0 || err_a !== 1'b1) begin
            n_errors++;
            $display("FAIL reserved_len: len %0d err %b required 0 1",
                     len_a, err_a);
        end
`else
        n_checks++;
        if (bus_a.mem_we !== 1'b1 || bus_a.mem_wdata !== 32'h0000_0013 ||
            err_a !== 1'b0) begin
            n_errors++;
            $display("FAIL reserved_nop: we %b wdata %h err %b required 1 00000013 0",
                     bus_a.mem_we, bus_a.mem_wdata, err_a);
        end
        step();
        n_checks++;
        if (len_a !== 9'd1 || err_a !== 1'b0) begin
            n_errors++;
            $display("FAIL reserved_len: len %0d err %b required 1 0",
                     len_a, err_a);
        end
`endif
    endtask

    task automatic test_rst_mid_write();
        bit ok;
        pulse_start_a();
        set_req(2'b00, 5'd1, 5'd0, 5'd0, 13'd5);
        send_a(ok);
        n_checks++;
        if (bus_a.mem_we !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_rst_write: we %b required 1", bus_a.mem_we);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus_a.req_ready, bus_a.mem_we, busy_a, done_a, full_a, err_a}
            !== 6'b0 || {bus_a.mem_addr, bus_a.mem_wdata, len_a} !== 49'h0) begin
            n_errors++;
            $display("FAIL rst_mid_write: flags %b addr %h wdata %h len %0d required 0",
                     {bus_a.req_ready, bus_a.mem_we, busy_a, done_a,
                      full_a, err_a}, bus_a.mem_addr, bus_a.mem_wdata, len_a);
        end
        step();
        rst = 1'b0;
        step();
        pulse_start_a();
        set_req(2'b00, 5'd3, 5'd0, 5'd0, 13'd7);
        send_a(ok);
        n_checks++;
        if (bus_a.mem_we !== 1'b1 || bus_a.mem_addr !== 8'd0 ||
            bus_a.mem_wdata !== 32'h0070_0193) begin
            n_errors++;
            $display("FAIL restart_write: we %b addr %h wdata %h required 1 00 00700193",
                     bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata);
        end
        step();
    endtask

    task automatic test_back_to_back_full();
        int writes;
        int hs;
        logic [1:0] exp_addr;
        bit addr_ok;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        bus_b.req_kind = 2'b00;
        bus_b.req_rd = 5'd1;
        bus_b.req_rs1 = 5'd1;
        bus_b.req_rs2 = 5'd0;
        bus_b.req_imm = 13'd1;
        bus_b.req_valid = 1'b1;
        writes = 0;
        hs = 0;
        exp_addr = 2'd0;
        addr_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (bus_b.req_ready === 1'b1 && hs < 6) hs++;
            step();
            if (bus_b.mem_we === 1'b1) begin
                if (bus_b.mem_addr !== exp_addr ||
                    bus_b.mem_wdata !== 32'h0010_8093) addr_ok = 1'b0;
                exp_addr = exp_addr + 2'd1;
                writes++;
            end
        end
        bus_b.req_valid = 1'b0;
        n_checks++;
        if (writes !== 4 || hs !== 4) begin
            n_errors++;
            $display("FAIL full_counts: writes %0d handshakes %0d required 4 4",
                     writes, hs);
        end
        n_checks++;
        if (!addr_ok) begin
            n_errors++;
            $display("FAIL full_addr_seq: addresses/data out of order, required 0..3 00108093");
        end
        n_checks++;
        if (full_b !== 1'b1 || done_b !== 1'b1 || len_b !== 3'd4 ||
            bus_b.req_ready !== 1'b0 || busy_b !== 1'b0) begin
            n_errors++;
            $display("FAIL full_state: full %b done %b len %0d ready %b busy %b required 1 1 4 0 0",
                     full_b, done_b, len_b, bus_b.req_ready, busy_b);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        start_a = 1'b0;
        finish_a = 1'b0;
        start_b = 1'b0;
        finish_b = 1'b0;
        bus_a.req_valid = 1'b0;
        bus_b.req_valid = 1'b0;
        set_req(2'b00, 5'd0, 5'd0, 5'd0, 13'd0);
        bus_b.req_kind = 2'b00;
        bus_b.req_rd = 5'd0;
        bus_b.req_rs1 = 5'd0;
        bus_b.req_rs2 = 5'd0;
        bus_b.req_imm = 13'd0;
        test_reset();
        test_addi();
        test_lw_bne();
        test_finish_same_cycle();
        test_start_wins();
        test_reserved();
        test_rst_mid_write();
        test_back_to_back_full();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
